multi_debouncer: RTL

Parametrised, multi-channel successor to the single-input button debouncer. Each channel synchronises an asynchronous pin, rejects bounces by requiring a stable level for a programmable number of cycles, and produces a level plus one-cycle rise, fall, long-press and auto-repeat pulses. It sits between the board buttons/switches and the UI/control FSMs.

---
 rtl/debounce_defs.sv | 17 +
 rtl/debounce_channel.sv | 162 ++++++++++++++++
 rtl/multi_debouncer.sv | 76 +++++++
 3 files changed

// File: rtl/debounce_defs.sv
// debounce_defs
//   Shared definitions for the multi-channel debouncer.
//   Holds the per-channel FSM state encoding and the minimum allowed
//   synchroniser depth. The state codes are chosen so that bit 1 equals
//   the debounced level (LOW/QUAL_HIGH -> 0, HIGH/QUAL_LOW -> 1).
package debounce_defs;

  typedef enum logic [1:0] {
    DB_LOW       = 2'b00,
    DB_QUAL_HIGH = 2'b01,
    DB_QUAL_LOW  = 2'b10,
    DB_HIGH      = 2'b11
  } db_state_t;

  localparam int DB_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One debounced input: synchroniser, qualification FSM, debounce counter,
//   hold/repeat counter and registered pulse outputs.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   pin          in   raw asynchronous input
//   level        out  debounced level
//   rise         out  1-cycle pulse when level goes 0->1
//   fall         out  1-cycle pulse when level goes 1->0
//   long_press   out  1-cycle pulse after HOLD_CYCLES in HIGH
//   repeat_pulse out  1-cycle pulse every REPEAT_CYCLES after long_press
module debounce_channel
  import debounce_defs::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int HOLD_WIDTH      = 27,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic repeat_pulse
);

  // Counters stop at these values and are cleared; they never wrap.
  localparam logic [CNT_WIDTH-1:0]  DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0] REP_LAST  = HOLD_WIDTH'(REPEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  db_state_t              state_reg;
  logic [CNT_WIDTH-1:0]   deb_cnt_reg;
  logic [HOLD_WIDTH-1:0]  hold_cnt_reg;
  logic                   rpt_phase_reg;
  logic                   level_reg;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   long_reg;
  logic                   rpt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= DB_LOW;
      deb_cnt_reg   <= '0;
      hold_cnt_reg  <= '0;
      rpt_phase_reg <= 1'b0;
      level_reg     <= 1'b0;
      rise_reg      <= 1'b0;
      fall_reg      <= 1'b0;
      long_reg      <= 1'b0;
      rpt_reg       <= 1'b0;
    end else begin
      // Pulses are single-cycle unless a branch below re-asserts them.
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      long_reg <= 1'b0;
      rpt_reg  <= 1'b0;

      case (state_reg)
        DB_LOW: begin
          deb_cnt_reg   <= '0;
          hold_cnt_reg  <= '0;
          rpt_phase_reg <= 1'b0;
          level_reg     <= 1'b0;
          if (s) state_reg <= DB_QUAL_HIGH;
        end

        DB_QUAL_HIGH: begin
          if (!s) begin
            // Glitch rejected: silently drop back.
            state_reg   <= DB_LOW;
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_reg     <= DB_HIGH;
            deb_cnt_reg   <= '0;
            level_reg     <= 1'b1;
            rise_reg      <= 1'b1;
            hold_cnt_reg  <= '0;
            rpt_phase_reg <= 1'b0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
        end

        DB_HIGH: begin
          deb_cnt_reg <= '0;
          if (!s) state_reg <= DB_QUAL_LOW;
          // Hold timing counts every HIGH cycle, including the one that
          // leaves for QUAL_LOW; it stays frozen while in QUAL_LOW.
          if (!rpt_phase_reg) begin
            if (hold_cnt_reg == HOLD_LAST) begin
              long_reg      <= 1'b1;
              hold_cnt_reg  <= '0;
              rpt_phase_reg <= 1'b1;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end else begin
            if (hold_cnt_reg == REP_LAST) begin
              rpt_reg      <= REPEAT_EN;
              hold_cnt_reg <= '0;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
        end

        DB_QUAL_LOW: begin
          if (s) begin
            state_reg   <= DB_HIGH;
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_reg     <= DB_LOW;
            deb_cnt_reg   <= '0;
            level_reg     <= 1'b0;
            fall_reg      <= 1'b1;
            hold_cnt_reg  <= '0;
            rpt_phase_reg <= 1'b0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg     <= DB_LOW;
          deb_cnt_reg   <= '0;
          hold_cnt_reg  <= '0;
          rpt_phase_reg <= 1'b0;
          level_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign level        = level_reg;
  assign rise         = rise_reg;
  assign fall         = fall_reg;
  assign long_press   = long_reg;
  assign repeat_pulse = rpt_reg;

endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer
//   CHANNELS independent debounced inputs with level, edge, long-press and
//   auto-repeat outputs. Each bit of every vector belongs to one channel.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   in           in   raw asynchronous pins
//   out          out  debounced levels
//   rise         out  1-cycle pulses on out 0->1
//   fall         out  1-cycle pulses on out 1->0
//   long_press   out  1-cycle pulses after HOLD_CYCLES held high
//   repeat_pulse out  1-cycle pulses every REPEAT_CYCLES after long_press
module multi_debouncer
  import debounce_defs::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int HOLD_WIDTH      = 27,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] repeat_pulse
);

  // Elaboration-time parameter range checks.
  if (CHANNELS < 1) begin : g_bad_channels
    $error("multi_debouncer: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < DB_MIN_SYNC_STAGES) begin : g_bad_sync
    $error("multi_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1 ||
      longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_bad_debounce
    $error("multi_debouncer: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_hold
    $error("multi_debouncer: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end
  if (longint'(HOLD_CYCLES) > (longint'(1) << HOLD_WIDTH) ||
      longint'(REPEAT_CYCLES) > (longint'(1) << HOLD_WIDTH)) begin : g_bad_hold_width
    $error("multi_debouncer: HOLD_WIDTH too small for HOLD/REPEAT_CYCLES");
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .HOLD_WIDTH     (HOLD_WIDTH),
      .REPEAT_EN      (REPEAT_EN)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .pin         (in[gi]),
      .level       (out[gi]),
      .rise        (rise[gi]),
      .fall        (fall[gi]),
      .long_press  (long_press[gi]),
      .repeat_pulse(repeat_pulse[gi])
    );
  end

endmodule
